// File: rtl/alu_mem_subsystem_if.sv
// Datapath bus between the register-file stage and the execute/memory slice.
// The master drives operands, memory controls and ROM loads; the slave returns ALU, memory and ROM results.
interface alu_mem_subsystem_if;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [63:0] alu_result;
  logic        alu_zero;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic [63:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_we;
  logic [63:0] imem_waddr;
  logic [31:0] imem_wdata;

  modport master (
    output alu_a, alu_b, alu_ctrl, mem_read, mem_write, mem_wdata,
           imem_addr, imem_we, imem_waddr, imem_wdata,
    input  alu_result, alu_zero, mem_rdata, imem_data
  );

  modport slave (
    input  alu_a, alu_b, alu_ctrl, mem_read, mem_write, mem_wdata,
           imem_addr, imem_we, imem_waddr, imem_wdata,
    output alu_result, alu_zero, mem_rdata, imem_data
  );
endinterface

// File: rtl/alu_mem_subsystem.sv
// Execute/memory slice of the single-cycle 64-bit datapath: a combinational ALU,
// a word-organised data memory addressed by the ALU result, and a loadable instruction ROM.
module alu_mem_subsystem #(
  parameter int DMEM_WORDS = 32,
  parameter int IMEM_WORDS = 64
) (
  input logic                 clk,
  input logic                 resetl,
  alu_mem_subsystem_if.slave  bus
);
  localparam int DIDX_W = $clog2(DMEM_WORDS);
  localparam int IIDX_W = $clog2(IMEM_WORDS);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  logic [63:0]       dataMem_q  [DMEM_WORDS];
  // ROM powers up as all-zero instructions; reset never touches it.
  logic [31:0]       instrRom_q [IMEM_WORDS] = '{default: 32'h0};

  logic [63:0]       aluResult;
  logic [DIDX_W-1:0] dmemIndex;
  logic [IIDX_W-1:0] imemIndex;
  logic [IIDX_W-1:0] imemLoadIndex;
  logic              unusedBits;

  always_comb begin
    aluResult = 64'd0;
    case (bus.alu_ctrl)
      ALU_AND:  aluResult = bus.alu_a & bus.alu_b;
      ALU_OR:   aluResult = bus.alu_a | bus.alu_b;
      ALU_ADD:  aluResult = bus.alu_a + bus.alu_b;
      ALU_SUB:  aluResult = bus.alu_a - bus.alu_b;
      ALU_PASS: aluResult = bus.alu_b;
      default:  aluResult = 64'd0;
    endcase
  end

  assign bus.alu_result = aluResult;
  assign bus.alu_zero   = (aluResult == 64'd0);

  // Byte offset within a word and address bits above the array simply alias.
  assign dmemIndex     = aluResult[3 +: DIDX_W];
  assign imemIndex     = bus.imem_addr[2 +: IIDX_W];
  assign imemLoadIndex = bus.imem_waddr[2 +: IIDX_W];

  assign bus.mem_rdata = bus.mem_read ? dataMem_q[dmemIndex] : 64'd0;
  assign bus.imem_data = instrRom_q[imemIndex];

  always_ff @(posedge clk) begin
    if (resetl) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dataMem_q[i] <= 64'd0;
      end
    end else if (bus.mem_write) begin
      dataMem_q[dmemIndex] <= bus.mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      instrRom_q[imemLoadIndex] <= bus.imem_wdata;
    end
  end

  assign unusedBits = ^{aluResult[2:0], aluResult[63:3+DIDX_W],
                        bus.imem_addr[1:0], bus.imem_addr[63:2+IIDX_W],
                        bus.imem_waddr[1:0], bus.imem_waddr[63:2+IIDX_W]};
endmodule

// File: tb/tb_alu_mem_subsystem.sv
// Directed bench for alu_mem_subsystem: stimulus pushes hand-computed expectations
// into a queue and a negedge monitor pops and compares them against the live outputs.
module tb_alu_mem_subsystem;
  logic clk;
  logic resetl;

  alu_mem_subsystem_if bus ();

  alu_mem_subsystem #(.DMEM_WORDS(32), .IMEM_WORDS(64)) dut (
    .clk    (clk),
    .resetl (resetl),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    string       name;
    logic [63:0] value;
  } expT;

  expT         expQ[$];
  expT         monEntry;
  logic [63:0] monActual;
  int          checks = 0;
  int          errors = 0;

  localparam logic [63:0] DEAD  = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] ALLF  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] INSN0 = 32'hF840_0000;
  localparam logic [31:0] INSN1 = 32'h8B01_0002;
  localparam logic [31:0] INSN2 = 32'hABCD_1234;

  function automatic void expectVal(input int kind, input string name, input logic [63:0] value);
    expT e;
    e.kind  = kind;
    e.name  = name;
    e.value = value;
    expQ.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Inputs only change just after a rising edge, so the falling edge sees settled outputs.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      monEntry = expQ.pop_front();
      case (monEntry.kind)
        0:       monActual = bus.alu_result;
        1:       monActual = {63'd0, bus.alu_zero};
        2:       monActual = bus.mem_rdata;
        default: monActual = {32'd0, bus.imem_data};
      endcase
      checkOutput(monEntry.name, monActual, monEntry.value);
    end
  end

  task automatic applyStimulus(
    input string       tag,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [3:0]  ctrl,
    input logic        rd,
    input logic        wr,
    input logic [63:0] wdata,
    input logic [63:0] iaddr,
    input logic [63:0] expRes,
    input logic        expZero,
    input logic [63:0] expRdata,
    input logic [31:0] expImem
  );
    @(posedge clk);
    #1;
    bus.alu_a     = a;
    bus.alu_b     = b;
    bus.alu_ctrl  = ctrl;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_wdata = wdata;
    bus.imem_addr = iaddr;
    expectVal(0, {tag, ".result"}, expRes);
    expectVal(1, {tag, ".zero"},   {63'd0, expZero});
    expectVal(2, {tag, ".rdata"},  expRdata);
    expectVal(3, {tag, ".imem"},   {32'd0, expImem});
  endtask

  initial begin
    resetl         = 1'b1;
    bus.alu_a      = '0;
    bus.alu_b      = '0;
    bus.alu_ctrl   = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_wdata  = '0;
    bus.imem_addr  = '0;
    bus.imem_we    = 1'b0;
    bus.imem_waddr = '0;
    bus.imem_wdata = '0;

    //             tag         a        b         ctrl     rd    wr    wdata     iaddr     res        z     rdata     imem
    applyStimulus("rst0",     64'h0,   64'h0,    4'b0000, 1'b1, 1'b0, 64'h0,    64'h0,    64'h0,     1'b1, 64'h0,    32'h0);
    resetl = 1'b0;
    applyStimulus("and",      64'h5,   64'h3,    4'b0000, 1'b0, 1'b0, 64'h0,    64'h0,    64'h1,     1'b0, 64'h0,    32'h0);
    bus.imem_we = 1'b1; bus.imem_waddr = 64'h0; bus.imem_wdata = INSN0;
    applyStimulus("or",       64'h5,   64'h3,    4'b0001, 1'b0, 1'b0, 64'h0,    64'h4,    64'h7,     1'b0, 64'h0,    32'h0);
    bus.imem_waddr = 64'h4; bus.imem_wdata = INSN1;
    applyStimulus("add",      64'h5,   64'h3,    4'b0010, 1'b0, 1'b0, 64'h0,    64'h0,    64'h8,     1'b0, 64'h0,    INSN0);
    bus.imem_we = 1'b0;
    applyStimulus("sub",      64'h5,   64'h3,    4'b0110, 1'b0, 1'b0, 64'h0,    64'h4,    64'h2,     1'b0, 64'h0,    INSN1);
    applyStimulus("passb",    64'h5,   64'h3,    4'b0111, 1'b0, 1'b0, 64'h0,    64'h6,    64'h3,     1'b0, 64'h0,    INSN1);
    applyStimulus("subeq",    64'h7,   64'h7,    4'b0110, 1'b0, 1'b0, 64'h0,    64'h100,  64'h0,     1'b1, 64'h0,    INSN0);
    applyStimulus("addwrap",  ALLF,    64'h1,    4'b0010, 1'b0, 1'b0, 64'h0,    64'h104,  64'h0,     1'b1, 64'h0,    INSN1);
    applyStimulus("subwrap",  64'h0,   64'h1,    4'b0110, 1'b0, 1'b0, 64'h0,    64'h7,    ALLF,      1'b0, 64'h0,    INSN1);
    applyStimulus("undefF",   64'h5,   64'h3,    4'b1111, 1'b0, 1'b0, 64'h0,    64'h0,    64'h0,     1'b1, 64'h0,    INSN0);
    applyStimulus("undef3",   64'h5,   64'h3,    4'b0011, 1'b0, 1'b0, 64'h0,    64'h0,    64'h0,     1'b1, 64'h0,    INSN0);
    applyStimulus("rdclr",    64'h10,  64'h8,    4'b0010, 1'b1, 1'b0, 64'h0,    64'h0,    64'h18,    1'b0, 64'h0,    INSN0);
    applyStimulus("wrold",    64'h10,  64'h8,    4'b0010, 1'b1, 1'b1, DEAD,     64'h0,    64'h18,    1'b0, 64'h0,    INSN0);
    applyStimulus("rdback",   64'h10,  64'h8,    4'b0010, 1'b1, 1'b0, 64'h0,    64'h0,    64'h18,    1'b0, DEAD,     INSN0);
    applyStimulus("rdoff",    64'h10,  64'h8,    4'b0010, 1'b0, 1'b0, 64'h0,    64'h0,    64'h18,    1'b0, 64'h0,    INSN0);
    applyStimulus("alias1f",  64'h0,   64'h1F,   4'b0111, 1'b1, 1'b0, 64'h0,    64'h0,    64'h1F,    1'b0, DEAD,     INSN0);
    applyStimulus("aliaswrap",64'h0,   64'h118,  4'b0111, 1'b1, 1'b0, 64'h0,    64'h0,    64'h118,   1'b0, DEAD,     INSN0);
    applyStimulus("wr100",    64'h0,   64'h100,  4'b0111, 1'b1, 1'b1, 64'h1111, 64'h0,    64'h100,   1'b0, 64'h0,    INSN0);
    applyStimulus("rd0",      64'h0,   64'h0,    4'b0111, 1'b1, 1'b0, 64'h0,    64'h0,    64'h0,     1'b1, 64'h1111, INSN0);
    applyStimulus("rd18keep", 64'h0,   64'h18,   4'b0111, 1'b1, 1'b0, 64'h0,    64'h0,    64'h18,    1'b0, DEAD,     INSN0);
    applyStimulus("rstwr",    64'h0,   64'h18,   4'b0111, 1'b1, 1'b1, 64'h5555, 64'h0,    64'h18,    1'b0, DEAD,     INSN0);
    resetl = 1'b1;
    bus.imem_we = 1'b1; bus.imem_waddr = 64'h8; bus.imem_wdata = INSN2;
    applyStimulus("rstclr",   64'h0,   64'h18,   4'b0111, 1'b1, 1'b0, 64'h0,    64'h8,    64'h18,    1'b0, 64'h0,    INSN2);
    resetl = 1'b0;
    bus.imem_we = 1'b0;
    applyStimulus("rstclr0",  64'h0,   64'h0,    4'b0111, 1'b1, 1'b0, 64'h0,    64'h0,    64'h0,     1'b1, 64'h0,    INSN0);
    applyStimulus("rstimem",  64'h0,   64'h20,   4'b0111, 1'b1, 1'b0, 64'h0,    64'h4,    64'h20,    1'b0, 64'h0,    INSN1);

    for (int i = 0; i < 20; i++) begin
      if (expQ.size() != 0) @(negedge clk);
    end
    #1;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
